// File: rtl/aq_ifu_fetch_ctrl_pkg.sv
// Shared definitions for the IFU fetch controller: FSM encoding and the
// outstanding-request limit.
package aq_ifu_fetch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RSTVEC = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_STALL  = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned OUTSTD_MAX     = 2;
  localparam logic [1:0]  OUTSTD_MAX_CNT = 2'(OUTSTD_MAX);

endpackage

// File: rtl/aq_ifu_fetch_outstd_cnt.sv
// Tracks granted-but-unreturned icache requests and the number of old-path
// returns to discard after a change of flow; qualifies blocks for the ibuf.
module aq_ifu_fetch_outstd_cnt
  import aq_ifu_fetch_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       grant_i,
  input  logic       inst_vld_i,
  input  logic       chgflw_i,
  output logic [1:0] outstd_cnt_o,
  output logic       ibuf_inst_vld_o
);

  logic [1:0] outstd_q, outstd_d;
  logic [1:0] kill_q, kill_d;
  logic       inst_eff;
  logic       inc;

  // A return with nothing outstanding is spurious and must not move any counter.
  assign inst_eff = inst_vld_i & (outstd_q != 2'd0);
  assign inc      = req_i & grant_i & (outstd_q != OUTSTD_MAX_CNT);

  always_comb begin
    outstd_d = outstd_q;
    if (inc && !inst_eff) begin
      outstd_d = outstd_q + 2'd1;
    end else if (!inc && inst_eff) begin
      outstd_d = outstd_q - 2'd1;
    end

    // A new change of flow reloads rather than accumulates, so the kill count
    // never exceeds what is actually still in flight.
    kill_d = kill_q;
    if (chgflw_i) begin
      kill_d = outstd_q - {1'b0, inst_eff};
    end else if (inst_eff && (kill_q != 2'd0)) begin
      kill_d = kill_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstd_q <= 2'd0;
      kill_q   <= 2'd0;
    end else begin
      outstd_q <= outstd_d;
      kill_q   <= kill_d;
    end
  end

  assign outstd_cnt_o    = outstd_q;
  assign ibuf_inst_vld_o = inst_vld_i & (kill_q == 2'd0) & ~chgflw_i & (outstd_q != 2'd0);

endmodule

// File: rtl/aq_ifu_fetch_ctrl.sv
// IFU fetch controller: sequences reset-vector load, fetch, stall and stop,
// and issues icache requests bounded by the outstanding-request limit.
module aq_ifu_fetch_ctrl
  import aq_ifu_fetch_ctrl_pkg::*;
(
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic       cp0_ifu_fetch_en,
  input  logic       rtu_ifu_stop_req,
  input  logic       pcgen_ctrl_chgflw_vld,
  input  logic       ibuf_ctrl_full,
  input  logic       icache_ctrl_grant,
  input  logic       icache_ctrl_inst_vld,
  output logic       ctrl_icache_req,
  output logic       ctrl_pcgen_rst_vld,
  output logic       ctrl_ibuf_inst_vld,
  output logic       ctrl_pcgen_idle,
  output logic       ctrl_rtu_stop_ack,
  output logic [1:0] ctrl_top_outstd_cnt
);

  logic [2:0] state_q, state_d;
  logic [1:0] outstd_cnt;
  logic       cnt_zero;

  assign cnt_zero = (outstd_cnt == 2'd0);

  // Stopping is only allowed once every granted request has come back, and
  // it wins over a simultaneous stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cp0_ifu_fetch_en) state_d = ST_RSTVEC;
      ST_RSTVEC: state_d = ST_FETCH;
      ST_FETCH: begin
        if (rtu_ifu_stop_req && cnt_zero) begin
          state_d = ST_STOP;
        end else if (ibuf_ctrl_full) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (rtu_ifu_stop_req && cnt_zero) begin
          state_d = ST_STOP;
        end else if (!ibuf_ctrl_full) begin
          state_d = ST_FETCH;
        end
      end
      ST_STOP:   if (!rtu_ifu_stop_req) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl_icache_req = (state_q == ST_FETCH) & ~ibuf_ctrl_full & ~rtu_ifu_stop_req
                         & ~pcgen_ctrl_chgflw_vld & (outstd_cnt < OUTSTD_MAX_CNT);

  aq_ifu_fetch_outstd_cnt u_outstd_cnt (
    .clk_i          (forever_cpuclk),
    .rst_i          (cpurst),
    .req_i          (ctrl_icache_req),
    .grant_i        (icache_ctrl_grant),
    .inst_vld_i     (icache_ctrl_inst_vld),
    .chgflw_i       (pcgen_ctrl_chgflw_vld),
    .outstd_cnt_o   (outstd_cnt),
    .ibuf_inst_vld_o(ctrl_ibuf_inst_vld)
  );

  assign ctrl_pcgen_rst_vld  = (state_q == ST_RSTVEC);
  assign ctrl_pcgen_idle     = (state_q == ST_IDLE) | ((state_q == ST_STOP) & cnt_zero);
  assign ctrl_rtu_stop_ack   = (state_q == ST_STOP);
  assign ctrl_top_outstd_cnt = outstd_cnt;

endmodule

// File: tb/tb_aq_ifu_fetch_ctrl.sv
// Directed-vector bench for aq_ifu_fetch_ctrl: each cycle's expected outputs
// are queued with the stimulus and checked by an independent monitor.
module tb_aq_ifu_fetch_ctrl;

  typedef struct packed {
    logic       req;
    logic       rstVld;
    logic       ibufVld;
    logic       idle;
    logic       stopAck;
    logic [1:0] cnt;
  } expT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetchEn = 1'b0;
  logic       stopReq = 1'b0;
  logic       chgflw = 1'b0;
  logic       ibufFull = 1'b0;
  logic       grant = 1'b0;
  logic       instVld = 1'b0;
  logic       req, rstVld, ibufVld, idle, stopAck;
  logic [1:0] cnt;

  expT expQ[$];
  int  vectorsApplied = 0;
  int  miscompares = 0;
  int  vecIdx = 0;
  bit  stimDone = 1'b0;

  always #5 clk = ~clk;

  aq_ifu_fetch_ctrl dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .cp0_ifu_fetch_en     (fetchEn),
    .rtu_ifu_stop_req     (stopReq),
    .pcgen_ctrl_chgflw_vld(chgflw),
    .ibuf_ctrl_full       (ibufFull),
    .icache_ctrl_grant    (grant),
    .icache_ctrl_inst_vld (instVld),
    .ctrl_icache_req      (req),
    .ctrl_pcgen_rst_vld   (rstVld),
    .ctrl_ibuf_inst_vld   (ibufVld),
    .ctrl_pcgen_idle      (idle),
    .ctrl_rtu_stop_ack    (stopAck),
    .ctrl_top_outstd_cnt  (cnt)
  );

  function automatic expT mkExp(input logic r, rv, ib, id, ack, input logic [1:0] c);
    expT e;
    e = '{req: r, rstVld: rv, ibufVld: ib, idle: id, stopAck: ack, cnt: c};
    return e;
  endfunction

  task automatic applyStimulus(input logic r, en, stop, chg, full, gnt, ivld, input expT e);
    @(posedge clk);
    #1;
    rst      = r;
    fetchEn  = en;
    stopReq  = stop;
    chgflw   = chg;
    ibufFull = full;
    grant    = gnt;
    instVld  = ivld;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e, input int idx);
    expT act;
    act = '{req: req, rstVld: rstVld, ibufVld: ibufVld, idle: idle, stopAck: stopAck, cnt: cnt};
    vectorsApplied++;
    if (act !== e) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: got req=%b rstVld=%b ibufVld=%b idle=%b stopAck=%b cnt=%0d, want req=%b rstVld=%b ibufVld=%b idle=%b stopAck=%b cnt=%0d",
               idx, act.req, act.rstVld, act.ibufVld, act.idle, act.stopAck, act.cnt,
               e.req, e.rstVld, e.ibufVld, e.idle, e.stopAck, e.cnt);
    end
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front(), vecIdx);
        vecIdx++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    //            rst en stp chg ful gnt ivl        req rv ib idl ack cnt
    applyStimulus(1, 0, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(1, 1, 0, 0, 0, 0, 1, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, mkExp(0, 1, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    // Grant every cycle until the limit masks the request, then one return.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 0, 1, 1, mkExp(0, 0, 1, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd1));
    // Change of flow with two in flight: two returns killed, third forwarded.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(1, 0, 1, 0, 0, 2'd1));
    // Change of flow coinciding with a return.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 1, 0, 0, 1, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    // Stop request waits for the outstanding return before acknowledging.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 1, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 1, 0, 0, 0, 1, mkExp(0, 0, 1, 0, 0, 2'd1));
    applyStimulus(0, 0, 1, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 1, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 1, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 1, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    // Spurious return with nothing outstanding, then an idle change of flow.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 1, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd0));
    // Reset while stalled with two in flight.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 1, 0, mkExp(1, 0, 0, 0, 0, 2'd1));
    applyStimulus(0, 0, 0, 0, 1, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(0, 0, 0, 0, 1, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd2));
    applyStimulus(1, 0, 0, 0, 1, 0, 0, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 1, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, mkExp(0, 1, 0, 0, 0, 2'd0));
    // Stall entry and exit.
    applyStimulus(0, 1, 0, 0, 1, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(0, 0, 0, 0, 0, 2'd0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, mkExp(1, 0, 0, 0, 0, 2'd0));
    stimDone = 1'b1;

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d unchecked vectors, want 0", expQ.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
